// File: rtl/rf_wport_arb.sv
// rf_wport_arb: register-file write-port arbiter (pipeline WB vs long-latency results)
// Optional macro LU_BYPASS_EN: empty-FIFO lu results drive the port in the same cycle.
module rf_wport_arb #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_waddr,
   input  logic [31:0] pipe_wdata,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_waddr,
   input  logic [31:0] lu_wdata,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_req,
   output logic [31:0] pending_mask
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [4:0]      e_addr [DEPTH];
   logic [31:0]     e_data [DEPTH];
   logic [DEPTH-1:0] e_v;
   logic [AW-1:0]   wr_idx, rd_idx;
   logic            pw, empty, full, head_valid, denied;
   logic            pop, push, push_v, bypass, next_empty;

   assign wr_idx     = wr_ptr[AW-1:0];
   assign rd_idx     = rd_ptr[AW-1:0];
   assign pw         = pipe_we && (pipe_waddr != 5'd0);
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_valid = !empty && e_v[rd_idx];
   assign denied     = pw && head_valid;
   assign lu_ready   = !full;
   assign push       = lu_valid && !full && !bypass;
   assign push_v     = (lu_waddr != 5'd0) &&
                       !(pw && (lu_waddr == pipe_waddr));
   assign wr_ptr_n   = wr_ptr + (AW+1)'(push);
   assign rd_ptr_n   = rd_ptr + (AW+1)'(pop);
   assign next_empty = (wr_ptr_n == rd_ptr_n);

   // Port grant: pipeline first, then FIFO head; invalid heads drain silently
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      pop      = 1'b0;
      bypass   = 1'b0;
      if (pw) begin
         rf_we    = 1'b1;
         rf_waddr = pipe_waddr;
         rf_wdata = pipe_wdata;
         pop      = !empty && !e_v[rd_idx];
      end else if (!empty) begin
         pop = 1'b1;
         if (e_v[rd_idx]) begin
            rf_we    = 1'b1;
            rf_waddr = e_addr[rd_idx];
            rf_wdata = e_data[rd_idx];
         end
      end
`ifdef LU_BYPASS_EN
      else if (lu_valid && (lu_waddr != 5'd0)) begin
         bypass   = 1'b1;
         rf_we    = 1'b1;
         rf_waddr = lu_waddr;
         rf_wdata = lu_wdata;
      end
`endif
      if (!resetn) begin
         rf_we    = 1'b0;
         rf_waddr = 5'd0;
         rf_wdata = 32'd0;
      end
   end

   // FIFO storage: WAW kill, pop, push
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         e_v    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_addr[i] <= 5'd0;
            e_data[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (pw && e_v[i] && (e_addr[i] == pipe_waddr))
               e_v[i] <= 1'b0;
         if (pop)
            e_v[rd_idx] <= 1'b0;
         if (push) begin
            e_addr[wr_idx] <= lu_waddr;
            e_data[wr_idx] <= lu_wdata;
            e_v[wr_idx]    <= push_v;
         end
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
      end
   end

   // Registers whose buffered result is still outstanding
   always_comb begin
      pending_mask = 32'd0;
      for (int i = 0; i < DEPTH; i++)
         if (e_v[i])
            pending_mask[e_addr[i]] = 1'b1;
      pending_mask[0] = 1'b0;
   end

   // Starvation next-state: count denials, hold DRAIN until the FIFO empties
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         RUN: begin
            if (pop || empty)
               cnt_n = '0;
            else if (denied) begin
               if (cnt == CNT_LAST) begin
                  state_n = DRAIN;
                  cnt_n   = '0;
               end else
                  cnt_n = cnt + 1'b1;
            end
         end
         DRAIN: begin
            cnt_n = '0;
            if (next_empty)
               state_n = RUN;
         end
         default: begin
            state_n = RUN;
            cnt_n   = '0;
         end
      endcase
   end

   // Starvation state, counter and registered stall request
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= RUN;
         cnt       <= '0;
         stall_req <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         stall_req <= (state_n == DRAIN);
      end
   end

endmodule
